// File: rtl/psram_init_seq_pkg.sv
// Shared types and constants for the PSRAM power-up / lock-recovery sequencer.
package psram_pkg;

    localparam int CFG_ADDR_W = 22;
    localparam int CFG_DATA_W = 16;

    // PSRAM-domain clock produced by the rPLL from the 27 MHz board clock
    localparam int CLK_FREQ_HZ = 54_000_000;
    localparam int CLK_PER_US  = CLK_FREQ_HZ / 1_000_000;

    // Device reset low time: 250 ns (200 ns minimum plus margin), rounded up to whole cycles
    localparam int DEF_RST_PULSE_CYCLES   = (CLK_PER_US * 250 + 999) / 1000;
    // Device power-up time after reset release: 150 us
    localparam int DEF_PWRUP_CYCLES       = CLK_PER_US * 150;
    localparam int DEF_LOCK_STABLE_CYCLES = 256;
    localparam int DEF_ACK_TIMEOUT        = 1024;
    localparam int DEF_MAX_RETRY          = 3;

    localparam logic [CFG_ADDR_W-1:0] DEF_CFG_ADDR = 22'h000800;
    localparam logic [CFG_DATA_W-1:0] DEF_CFG_DATA = 16'h8FE4;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        RST_PULSE,
        PWRUP,
        CFG_REQ,
        READY,
        ERROR
    } init_state_t;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/psram_init_seq_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous input through two flops to settle metastability
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/psram_init_seq.sv
// Sequencer that brings the PSRAM and its controller out of reset after a stable
// PLL lock, writes one configuration register, and restarts on any lock loss.
module psram_init_seq
    import psram_pkg::*;
#(
    parameter int                     LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int                     RST_PULSE_CYCLES   = DEF_RST_PULSE_CYCLES,
    parameter int                     PWRUP_CYCLES       = DEF_PWRUP_CYCLES,
    parameter int                     ACK_TIMEOUT        = DEF_ACK_TIMEOUT,
    parameter int                     MAX_RETRY          = DEF_MAX_RETRY,
    parameter logic [CFG_ADDR_W-1:0]  CFG_ADDR           = DEF_CFG_ADDR,
    parameter logic [CFG_DATA_W-1:0]  CFG_DATA           = DEF_CFG_DATA
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pll_lock,
    output logic                  o_ram_rst_n,
    output logic                  o_ctrl_rst,
    output logic                  o_cfg_req,
    output logic [CFG_ADDR_W-1:0] o_cfg_addr,
    output logic [CFG_DATA_W-1:0] o_cfg_data,
    input  logic                  i_cfg_ack,
    output logic                  o_init_done,
    output logic                  o_init_err,
    output logic [7:0]            o_lock_lost_cnt
);

    // One shared phase counter sized for the longest timed phase
    localparam int MAX_CYC = maxOf(maxOf(LOCK_STABLE_CYCLES, RST_PULSE_CYCLES),
                                   maxOf(PWRUP_CYCLES, ACK_TIMEOUT));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RETRY_LAST = RTY_W'(MAX_RETRY - 1);

    init_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [RTY_W-1:0]      r_retryCnt;
    logic                  r_ramRstN;
    logic                  r_ctrlRst;
    logic                  r_cfgReq;
    logic [CFG_ADDR_W-1:0] r_cfgAddr;
    logic [CFG_DATA_W-1:0] r_cfgData;
    logic                  r_initDone;
    logic                  r_initErr;
    logic [7:0]            r_lostCnt;
    logic                  w_lockSync;
    logic                  w_lockLoss;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_lock_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_pll_lock),
        .o_q   (w_lockSync)
    );

    // A lock drop only counts as a loss once the device has started being reset
    assign w_lockLoss = !w_lockSync && (r_state != WAIT_LOCK) && (r_state != SETTLE);

    // Sequencer FSM; every output is registered and updated together with the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_retryCnt <= '0;
            r_ramRstN  <= 1'b0;
            r_ctrlRst  <= 1'b1;
            r_cfgReq   <= 1'b0;
            r_cfgAddr  <= '0;
            r_cfgData  <= '0;
            r_initDone <= 1'b0;
            r_initErr  <= 1'b0;
            r_lostCnt  <= '0;
        end else if (w_lockLoss) begin
            r_state    <= WAIT_LOCK;
            r_cnt      <= '0;
            r_retryCnt <= '0;
            r_ramRstN  <= 1'b0;
            r_ctrlRst  <= 1'b1;
            r_cfgReq   <= 1'b0;
            r_cfgAddr  <= '0;
            r_cfgData  <= '0;
            r_initDone <= 1'b0;
            r_initErr  <= 1'b0;
            if (r_lostCnt != 8'hFF) begin
                r_lostCnt <= r_lostCnt + 8'd1;
            end
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (w_lockSync) begin
                        r_state <= SETTLE;
                        r_cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (!w_lockSync) begin
                        r_state <= WAIT_LOCK;
                        r_cnt   <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state <= RST_PULSE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RST_PULSE: begin
                    if (r_cnt == PULSE_LAST) begin
                        r_state   <= PWRUP;
                        r_cnt     <= '0;
                        r_ramRstN <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                PWRUP: begin
                    if (r_cnt == PWRUP_LAST) begin
                        r_state    <= CFG_REQ;
                        r_cnt      <= '0;
                        r_retryCnt <= '0;
                        r_ctrlRst  <= 1'b0;
                        r_cfgReq   <= 1'b1;
                        r_cfgAddr  <= CFG_ADDR;
                        r_cfgData  <= CFG_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                CFG_REQ: begin
                    if (!r_cfgReq) begin
                        r_cfgReq  <= 1'b1;
                        r_cnt     <= '0;
                        r_cfgAddr <= CFG_ADDR;
                        r_cfgData <= CFG_DATA;
                    end else if (i_cfg_ack) begin
                        r_state    <= READY;
                        r_cfgReq   <= 1'b0;
                        r_cfgAddr  <= '0;
                        r_cfgData  <= '0;
                        r_initDone <= 1'b1;
                    end else if (r_cnt == ACK_LAST) begin
                        r_cnt     <= '0;
                        r_cfgReq  <= 1'b0;
                        r_cfgAddr <= '0;
                        r_cfgData <= '0;
                        if (r_retryCnt == RETRY_LAST) begin
                            r_state   <= ERROR;
                            r_initErr <= 1'b1;
                        end else begin
                            r_retryCnt <= r_retryCnt + RTY_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                READY: begin
                end
                ERROR: begin
                end
                default: begin
                    r_state <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign o_ram_rst_n     = r_ramRstN;
    assign o_ctrl_rst      = r_ctrlRst;
    assign o_cfg_req       = r_cfgReq;
    assign o_cfg_addr      = r_cfgAddr;
    assign o_cfg_data      = r_cfgData;
    assign o_init_done     = r_initDone;
    assign o_init_err      = r_initErr;
    assign o_lock_lost_cnt = r_lostCnt;

endmodule

// File: doc/psram_init_seq.md
Name: psram_init_seq

Overview:
- Power-up and lock-recovery sequencer between the rPLL and the PSRAM controller, in the PSRAM clock domain (54 MHz from the 27 MHz board clock).
- Waits for a stable PLL lock, then pulses the PSRAM reset pin and observes the device power-up time.
- Releases the controller from reset and writes one configuration register through the controller's request/ack port.
- Restarts the whole sequence when lock is lost and exposes init_done and init_err status.

Parameters:
LOCK_STABLE_CYCLES, 256, consecutive synced-lock cycles required before sequencing
RST_PULSE_CYCLES, 14, ram_rst_n low time (>=200 ns at 54 MHz)
PWRUP_CYCLES, 8100, wait after ram_rst_n rises (150 us at 54 MHz)
ACK_TIMEOUT, 1024, cycles to wait for cfg_ack before retry
MAX_RETRY, 3, configuration attempts before init_err
CFG_ADDR, 22'h000800, register-space address of the config word
CFG_DATA, 16'h8FE4, configuration word written at init

Ports:
clk  in  1  PSRAM-domain clock (PLL clkout)
rst  in  1  synchronous active-high reset
pll_lock  in  1  PLL lock, asynchronous to clk
ram_rst_n  out  1  PSRAM device reset pin, active low
ctrl_rst  out  1  PSRAM controller reset, active high
cfg_req  out  1  config write request
cfg_addr  out  22  config address, valid while cfg_req=1
cfg_data  out  16  config data, valid while cfg_req=1
cfg_ack  in  1  controller accepted the config write (1-cycle pulse)
init_done  out  1  sequence complete, RAM usable
init_err  out  1  configuration failed after MAX_RETRY attempts
lock_lost_cnt  out  8  saturating count of lock-loss events

Behaviour:
- Decided interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: ram_rst_n=0, ctrl_rst=1, cfg_req=0, cfg_addr=0, cfg_data=0, init_done=0, init_err=0, lock_lost_cnt=0. FSM enters WAIT_LOCK and all counters clear.
- Lock synchronizer: 2-flop, reset to 0. lock_s is the synchronizer output, 2-cycle latency.
- WAIT_LOCK: ram_rst_n=0, ctrl_rst=1. Go to SETTLE when lock_s=1.
- SETTLE: count lock_s=1 cycles. If lock_s drops, return to WAIT_LOCK; this is not counted as a loss. After LOCK_STABLE_CYCLES, go to RST_PULSE.
- RST_PULSE: ram_rst_n=0 for exactly RST_PULSE_CYCLES, then go to PWRUP.
- PWRUP: ram_rst_n=1, ctrl_rst=1 for exactly PWRUP_CYCLES, then go to CFG_REQ.
- CFG_REQ: ctrl_rst=0; cfg_req=1 with cfg_addr=CFG_ADDR, cfg_data=CFG_DATA. Hold these stable until cfg_ack is sampled.
  - cfg_ack=1: next cycle cfg_req=0 and init_done=1 (state READY).
  - ACK_TIMEOUT cycles without ack: drop cfg_req for 1 cycle and retry.
  - MAX_RETRY failed attempts: go to ERROR with init_err=1, cfg_req=0, ctrl_rst=0. ERROR exits only via rst or a lock loss.
- cfg_ack while cfg_req=0 is ignored. An ack in the same cycle the timeout expires counts as success.
- Lock loss: lock_s=0 in RST_PULSE, PWRUP, CFG_REQ, READY or ERROR. Next cycle:
  - ram_rst_n=0, ctrl_rst=1, cfg_req=0, init_done=0, init_err=0
  - retry count clears; lock_lost_cnt increments, saturating at 255
  - FSM goes to WAIT_LOCK
- Lock loss has priority over every other transition in the same cycle.
- Counters use $clog2(max parameter+1) widths. Terminal compares are exact: a pulse of N cycles is N clocks, checked at count N-1.
- rst asserted mid-sequence returns every output to its reset value on the next edge, including lock_lost_cnt.

Decomposition:
- Shared package psram_pkg holds:
  - FSM state enum: WAIT_LOCK, SETTLE, RST_PULSE, PWRUP, CFG_REQ, READY, ERROR
  - CFG_ADDR_W=22, CFG_DATA_W=16
  - default timing constants derived from CLK_FREQ_HZ=54_000_000
- One sub-module, sync_2ff (parameterised reset value), used for pll_lock.

Test Plan:
- Use LOCK_STABLE_CYCLES=8, RST_PULSE_CYCLES=4, PWRUP_CYCLES=20, ACK_TIMEOUT=10, MAX_RETRY=3.
- Nominal: pll_lock rises at cycle 5, ack 3 cycles after cfg_req. Expect lock_s at cycle 7; ram_rst_n low through cycle 19, high at cycle 20; ctrl_rst falls and cfg_req rises at cycle 40 with addr 0x000800 and data 0x8FE4; init_done=1 the cycle after ack.
- Glitch in SETTLE: lock drops after 5 stable cycles. Expect SETTLE to restart, no reset pulse, lock_lost_cnt stays 0.
- Timeout retry: no ack. Expect cfg_req high 10 cycles, low 1, repeated 3 times; then init_err=1 and cfg_req=0.
- Ack on the 2nd attempt: expect exactly 2 req pulses and init_done=1, init_err=0.
- Lock loss in READY: expect next cycle init_done=0, ram_rst_n=0, ctrl_rst=1, lock_lost_cnt=1; full sequence reruns when lock returns.
- Saturation and reset: 260 lock-loss events give lock_lost_cnt=255; then rst asserted mid-PWRUP clears all outputs to reset values on the next edge.
